adc_sample_averager: RTL
========================

# adc_sample_averager

Downstream stage of the SPI ADC controller. Consumes the controller's one-cycle `adc_dval` strobe with its parallel `adc_data` word and accumulates 2^AVG_LOG2 consecutive samples. It then writes the block average into a small first-word-fall-through FIFO, which the consumer drains over a valid/ready handshake. An overflow flag reports averages dropped because the FIFO was full.

## Interface
- `DATA_W`, default `` `ADC_DATA_WIDTH `` (12): sample and average width.
- `AVG_LOG2`, default 2: log2 of samples per average. Legal range 0..6; 0 gives pass-through.
- `FIFO_AW`, default 2: log2 of FIFO depth (4 entries).

- `clk`  in  1  : single system clock, shared with the ADC controller.
- `rstn`  in  1  : asynchronous, active-low reset.
- `avg_clr`  in  1  : synchronous clear of accumulator, counter, FIFO and `ovf_flag`.
- `adc_dval`  in  1  : sample strobe, one cycle per sample.
- `adc_data`  in  DATA_W : sample, valid while `adc_dval`=1.
- `out_valid`  out  1  : FIFO head valid.
- `out_data`  out  DATA_W : FIFO head (average).
- `out_ready`  in  1  : consumer accepts head.
- `fifo_level`  out  FIFO_AW+1 : entries held, 0..2^FIFO_AW.
- `ovf_flag`  out  1  : sticky; an average was dropped.

## Operation
- Accumulator `acc` is DATA_W+AVG_LOG2 bits wide; sample counter `cnt` is AVG_LOG2 bits wide.
- On `adc_dval`=1 with `cnt` < 2^AVG_LOG2−1:
  - `acc` += `adc_data`;
  - `cnt`++.
- On `adc_dval`=1 with `cnt` = 2^AVG_LOG2−1 (final sample):
  - compute sum = `acc` + `adc_data`;
  - average = sum >> AVG_LOG2, optionally rounded (see Configuration);
  - push the average into the FIFO;
  - `acc`←0, `cnt`←0.
- Unsigned arithmetic only. The sum never exceeds the accumulator width.
- FIFO:
  - circular buffer with read/write pointers of FIFO_AW+1 bits;
  - full when the pointer MSBs differ and the lower bits are equal; empty when the pointers are equal.
  - Pop occurs when `out_valid` && `out_ready`.
- Push while full with no pop in the same cycle: the average is discarded, `ovf_flag`←1, and accumulation restarts normally.
- Push while full with a pop in the same cycle: the push is accepted and the level is unchanged.
- Push while empty: `out_valid` rises the next cycle.
- `avg_clr`=1 has priority over everything:
  - clears `acc`, `cnt`, both FIFO pointers and `ovf_flag`;
  - a coincident `adc_dval` sample is discarded;
  - a coincident pop is ignored.
- `ovf_flag` clears only on `avg_clr` or reset.
- Reset mid-block discards the partial sum; the next sample after reset is the first of a new block.
- Reset values:
  - `out_valid`=0, `out_data`=0, `fifo_level`=0, `ovf_flag`=0;
  - `acc`=0, `cnt`=0.

## Timing
- All state changes on `posedge clk`; `rstn` acts asynchronously on its falling edge.
- Latency: final-sample `adc_dval` in cycle n → FIFO write at the closing edge of n. With the FIFO previously empty, `out_valid`=1 and `out_data` valid from cycle n+1.
- `out_data` is driven from the head register. It is stable while `out_valid`=1 and `out_ready`=0.
- The block accepts `adc_dval` on every cycle; there is no backpressure toward the ADC controller.
- `fifo_level` updates in the cycle after a push or pop.
- Throughput: one average per 2^AVG_LOG2 strobes; one pop per cycle.

## Configuration
- `ADC_AVG_ROUND_EN` defined: average = (sum + 2^(AVG_LOG2−1)) >> AVG_LOG2, i.e. round-half-up. For AVG_LOG2=0 no offset is added. The result never exceeds 2^DATA_W−1, so no saturation is needed.
- `ADC_AVG_ROUND_EN` undefined: average = sum >> AVG_LOG2 (truncation).

## Structure
- `adc_defines.v` holds `ADC_DATA_WIDTH`, plus the new defaults `ADC_AVG_LOG2` and `ADC_AVG_FIFO_AW`. Parameter defaults reference these.
- Sub-module `adc_sync_fifo` (parameters DATA_W, FIFO_AW) provides FWFT storage, pointers, level, and full/empty. It is reusable by later ADC blocks.
- The top level contains the accumulator, counter, rounding and overflow logic.

## Test plan
- DATA_W=12, AVG_LOG2=2, samples 100,101,102,103 → `out_data`=101 when truncating, 102 with `ADC_AVG_ROUND_EN`. `out_valid` is high the cycle after the 4th strobe.
- Four samples of 4095 with rounding → `out_data`=4095; no wrap.
- `out_ready`=0, 5 blocks of samples → `fifo_level`=4, the 5th average dropped, `ovf_flag`=1. Draining then yields the first four averages in order.
- FIFO full with `out_ready`=1 in the same cycle as the final-sample strobe → push accepted, `fifo_level` stays 4, `ovf_flag` stays 0.
- `avg_clr` asserted after 2 of 4 samples together with a strobe → `cnt`=0, FIFO empty, `ovf_flag`=0. The next 4 samples 8,8,8,8 give 8.
- Assert `rstn` low mid-block with FIFO holding 2 entries → all outputs are 0 immediately. After release, 4 samples 40,40,40,40 → 40.

Source files
------------

// File: rtl/adc_sample_averager_pkg.sv
// adc_sample_averager_pkg: default widths and depths for the ADC averaging path
`ifndef ADC_DATA_WIDTH
`define ADC_DATA_WIDTH 12
`endif
`ifndef ADC_AVG_LOG2
`define ADC_AVG_LOG2 2
`endif
`ifndef ADC_AVG_FIFO_AW
`define ADC_AVG_FIFO_AW 2
`endif
package adc_sample_averager_pkg;
  localparam int unsigned ADC_DATA_W_DEF   = `ADC_DATA_WIDTH;
  localparam int unsigned ADC_AVG_LOG2_DEF = `ADC_AVG_LOG2;
  localparam int unsigned ADC_FIFO_AW_DEF  = `ADC_AVG_FIFO_AW;
endpackage

// File: rtl/adc_sync_fifo.sv
// adc_sync_fifo: first-word-fall-through FIFO with level and full flag
module adc_sync_fifo #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic              full,
  output logic [FIFO_AW:0]  level
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  logic [FIFO_AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic empty, wr_en, rd_en;
  // flags, head output and pointer next state; a pop frees room for a same-cycle push
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q ^ rd_q) == {1'b1, {FIFO_AW{1'b0}}};
    rd_en = pop && !empty && !clr;
    wr_en = push && !clr && (!full || rd_en);
    wr_d = clr ? '0 : wr_q + (FIFO_AW+1)'(wr_en);
    rd_d = clr ? '0 : rd_q + (FIFO_AW+1)'(rd_en);
    valid = !empty;
    rdata = empty ? '0 : mem_q[rd_q[FIFO_AW-1:0]];
    level = wr_q - rd_q;
  end
  // pointer registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[FIFO_AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/adc_sample_averager.sv
// adc_sample_averager: block-average ADC samples into a FIFO (ADC_AVG_ROUND_EN enables round-half-up)
module adc_sample_averager
  import adc_sample_averager_pkg::*;
#(
  parameter int unsigned DATA_W   = ADC_DATA_W_DEF,
  parameter int unsigned AVG_LOG2 = ADC_AVG_LOG2_DEF,
  parameter int unsigned FIFO_AW  = ADC_FIFO_AW_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              avg_clr,
  input  logic              adc_dval,
  input  logic [DATA_W-1:0] adc_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              ovf_flag
);
  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
`ifdef ADC_AVG_ROUND_EN
  localparam logic [ACC_W-1:0] RND = ACC_W'((1 << AVG_LOG2) >> 1);
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum, avg_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] avg;
  logic ovf_q, ovf_d, last, push, pop, full;
  // final-sample detection, average and accumulator/counter/overflow next state; clear wins
  always_comb begin
    last = adc_dval && (cnt_q == CNT_LAST);
    acc_sum = acc_q + ACC_W'(adc_data);
    avg_sum = acc_sum + RND;
    avg = DATA_W'(avg_sum >> AVG_LOG2);
    push = last && !avg_clr;
    pop = out_valid && out_ready && !avg_clr;
    acc_d = (avg_clr || last) ? '0 : adc_dval ? acc_sum : acc_q;
    cnt_d = (avg_clr || last) ? '0 : adc_dval ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_d = !avg_clr && (ovf_q || (push && full && !pop));
  end
  // accumulator, sample counter and sticky overflow registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign ovf_flag = ovf_q;
  adc_sync_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (avg_clr),
    .push  (push),
    .wdata (avg),
    .pop   (out_ready),
    .rdata (out_data),
    .valid (out_valid),
    .full  (full),
    .level (fifo_level)
  );
endmodule
